bram_fifo_ctrl: RTL and testbench

Synchronous FIFO controller that drives one TDP_RAM36K configured 36 bits wide: port A write only, port B read only.
- Generates write/read enables, word addresses and byte enables, and tracks occupancy.
- Presents a standard (non-show-ahead) FIFO interface to fabric logic.
- Sits directly upstream of the RAM primitive and also consumes its port-B read data; it is the stage the BRAM FIFO inference maps onto.

---
 rtl/bram_fifo_ctrl_if.sv | 48 ++++
 rtl/bram_fifo_ctrl.sv | 115 +++++++++++
 tb/tb_bram_fifo_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/bram_fifo_ctrl_if.sv
// Purpose: fabric-side FIFO handshake plus TDP_RAM36K port-A/port-B wiring for bram_fifo_ctrl.
// Latency: none, signal bundle only.
// Backpressure: FULL/EMPTY flags qualify WR_EN/RD_EN; requests against a blocked side are dropped and flagged.
// Ports: slave = controller view, master = fabric + RAM view (drives requests and RAM read data).
interface bram_fifo_ctrl_if #(
    parameter int ADDR_WIDTH = 10
);
    // fabric write side
    logic                  WR_EN;
    logic [35:0]           WR_DATA;
    logic                  FULL;
    logic                  ALMOST_FULL;
    logic                  OVERFLOW;
    // fabric read side
    logic                  RD_EN;
    logic [35:0]           RD_DATA;
    logic                  RD_VALID;
    logic                  EMPTY;
    logic                  ALMOST_EMPTY;
    logic                  UNDERFLOW;
    logic [ADDR_WIDTH:0]   COUNT;
    logic                  PARITY_ERR;
    // RAM port A (write only)
    logic                  RAM_WEN_A;
    logic [3:0]            RAM_BE_A;
    logic [14:0]           RAM_ADDR_A;
    logic [31:0]           RAM_WDATA_A;
    logic [3:0]            RAM_WPARITY_A;
    // RAM port B (read only)
    logic                  RAM_REN_B;
    logic [14:0]           RAM_ADDR_B;
    logic [31:0]           RAM_RDATA_B;
    logic [3:0]            RAM_RPARITY_B;

    modport slave (
        input  WR_EN, WR_DATA, RD_EN, RAM_RDATA_B, RAM_RPARITY_B,
        output FULL, ALMOST_FULL, OVERFLOW, RD_DATA, RD_VALID, EMPTY, ALMOST_EMPTY,
               UNDERFLOW, COUNT, PARITY_ERR, RAM_WEN_A, RAM_BE_A, RAM_ADDR_A,
               RAM_WDATA_A, RAM_WPARITY_A, RAM_REN_B, RAM_ADDR_B
    );

    modport master (
        output WR_EN, WR_DATA, RD_EN, RAM_RDATA_B, RAM_RPARITY_B,
        input  FULL, ALMOST_FULL, OVERFLOW, RD_DATA, RD_VALID, EMPTY, ALMOST_EMPTY,
               UNDERFLOW, COUNT, PARITY_ERR, RAM_WEN_A, RAM_BE_A, RAM_ADDR_A,
               RAM_WDATA_A, RAM_WPARITY_A, RAM_REN_B, RAM_ADDR_B
    );
endinterface

// File: rtl/bram_fifo_ctrl.sv
// Purpose: synchronous non-show-ahead FIFO controller driving one TDP_RAM36K (36-bit, A write / B read).
// Latency: RD_VALID/RD_DATA two edges after an accepted RD_EN; flags/COUNT update the edge after the request.
// Backpressure: writes dropped while FULL (OVERFLOW pulse), reads dropped while EMPTY (UNDERFLOW pulse).
// Ports: CLK, RESET (sync, active-high), bus (bram_fifo_ctrl_if.slave: fabric FIFO side + RAM ports).
// Option: define BRAM_FIFO_CTRL_PARITY_EN to generate/check even byte parity in the RAM parity lane.
module bram_fifo_ctrl #(
    parameter int ADDR_WIDTH      = 10,
    parameter int ALMOST_FULL_TH  = 1016,
    parameter int ALMOST_EMPTY_TH = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    bram_fifo_ctrl_if.slave   bus
);
    localparam int                  DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_TH   = (ADDR_WIDTH+1)'(ALMOST_FULL_TH);
    localparam logic [ADDR_WIDTH:0] AE_TH   = (ADDR_WIDTH+1)'(ALMOST_EMPTY_TH);

    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   count_q, count_nxt;
    logic                  full_q, almost_full_q, empty_q, almost_empty_q;
    logic                  overflow_q, underflow_q;
    logic                  rd_inflight;     // RAM port B output is valid this cycle
    logic                  rd_valid_q;
    logic [35:0]           rd_data_q;
    logic                  parity_err_q;
    logic                  wr_acc, rd_acc;
    logic [3:0]            wparity;
    logic                  par_mismatch;

    // No RAM traffic while held in reset so the block contents survive it.
    assign wr_acc = bus.WR_EN & ~full_q  & ~RESET;
    assign rd_acc = bus.RD_EN & ~empty_q & ~RESET;

    always_comb begin
        count_nxt = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count_q + (ADDR_WIDTH+1)'(1);
            2'b01:   count_nxt = count_q - (ADDR_WIDTH+1)'(1);
            default: count_nxt = count_q;
        endcase
    end

`ifdef BRAM_FIFO_CTRL_PARITY_EN
    // Parity lane carries even byte parity; recomputed on the way back out.
    logic [3:0] rparity_calc;
    always_comb begin
        wparity      = '0;
        rparity_calc = '0;
        for (int i = 0; i < 4; i++) begin
            wparity[i]      = ^bus.WR_DATA[8*i +: 8];
            rparity_calc[i] = ^bus.RAM_RDATA_B[8*i +: 8];
        end
        par_mismatch = (rparity_calc != bus.RAM_RPARITY_B);
    end
`else
    // Parity lane is just four more data bits.
    assign wparity      = bus.WR_DATA[35:32];
    assign par_mismatch = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            almost_full_q  <= 1'b0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            rd_inflight    <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_data_q      <= '0;
            parity_err_q   <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (rd_acc) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            count_q        <= count_nxt;
            // Flags come from count_nxt so they line up with COUNT.
            full_q         <= (count_nxt == DEPTH_C);
            almost_full_q  <= (count_nxt >= AF_TH);
            empty_q        <= (count_nxt == '0);
            almost_empty_q <= (count_nxt <= AE_TH);
            overflow_q     <= bus.WR_EN & full_q;
            underflow_q    <= bus.RD_EN & empty_q;
            rd_inflight    <= rd_acc;
            rd_valid_q     <= rd_inflight;
            if (rd_inflight) rd_data_q <= {bus.RAM_RPARITY_B, bus.RAM_RDATA_B};
            parity_err_q   <= rd_inflight & par_mismatch;
        end
    end

    // Word address sits at ADDR[14:5] for the 36-bit aspect ratio.
    assign bus.RAM_WEN_A     = wr_acc;
    assign bus.RAM_BE_A      = {4{wr_acc}};
    assign bus.RAM_ADDR_A    = 15'({wr_ptr, 5'b00000});
    assign bus.RAM_WDATA_A   = bus.WR_DATA[31:0];
    assign bus.RAM_WPARITY_A = wparity;
    assign bus.RAM_REN_B     = rd_acc;
    assign bus.RAM_ADDR_B    = 15'({rd_ptr, 5'b00000});

    assign bus.FULL          = full_q;
    assign bus.ALMOST_FULL   = almost_full_q;
    assign bus.OVERFLOW      = overflow_q;
    assign bus.EMPTY         = empty_q;
    assign bus.ALMOST_EMPTY  = almost_empty_q;
    assign bus.UNDERFLOW     = underflow_q;
    assign bus.COUNT         = count_q;
    assign bus.RD_VALID      = rd_valid_q;
    assign bus.RD_DATA       = rd_data_q;
    assign bus.PARITY_ERR    = parity_err_q;
endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Purpose: directed self-checking bench for bram_fifo_ctrl with a behavioural TDP_RAM36K model.
// Latency: RAM model returns port-B data one edge after REN_B.
// Backpressure: bench obeys nothing; it deliberately over-writes and over-reads to hit the flags.
module tb_bram_fifo_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   err_cnt = 0;
    int   chk_cnt = 0;

    always #5 clk = ~clk;

    bram_fifo_ctrl_if #(.ADDR_WIDTH(10)) bus ();

    bram_fifo_ctrl #(
        .ADDR_WIDTH(10), .ALMOST_FULL_TH(1016), .ALMOST_EMPTY_TH(8)
    ) dut (
        .CLK(clk), .RESET(rst), .bus(bus)
    );

    // RAM model: 1024 x 36, registered read.
    logic [35:0] mem [1024];
    logic [35:0] ram_q = '0;
    logic        flip_par = 1'b0;
    always @(posedge clk) begin
        if (bus.RAM_WEN_A) mem[bus.RAM_ADDR_A[14:5]] <= {bus.RAM_WPARITY_A, bus.RAM_WDATA_A};
        if (bus.RAM_REN_B) ram_q <= mem[bus.RAM_ADDR_B[14:5]];
    end
    assign bus.RAM_RDATA_B   = ram_q[31:0];
    assign bus.RAM_RPARITY_B = ram_q[35:32] ^ {3'b000, flip_par};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          model_cnt;
        int          written;
        int          cyc;
        bit          saw_wrap;
        bit          had_prev;
        logic [9:0]  prev_wa;
        logic [35:0] wdata;
        logic [35:0] exp_q[$];
        logic [35:0] rd_q[$];
        logic        w, r, aw, ar;
        logic [35:0] exp5;

        bus.WR_EN = 1'b0; bus.RD_EN = 1'b0; bus.WR_DATA = '0;

        // ---- 1: reset state and underflow
        rst = 1'b1; step(); step();
        rst = 1'b0; step();
        chk("t1_empty", bus.EMPTY, 1);
        chk("t1_aempty", bus.ALMOST_EMPTY, 1);
        chk("t1_full", bus.FULL, 0);
        chk("t1_afull", bus.ALMOST_FULL, 0);
        chk("t1_count", bus.COUNT, 0);
        chk("t1_rd_valid", bus.RD_VALID, 0);
        chk("t1_rd_data", bus.RD_DATA, 0);
        chk("t1_wen", bus.RAM_WEN_A, 0);
        chk("t1_be", bus.RAM_BE_A, 0);
        chk("t1_parity_err", bus.PARITY_ERR, 0);
        bus.RD_EN = 1'b1; #1;
        chk("t1_ren_blocked", bus.RAM_REN_B, 0);
        step();
        chk("t1_underflow", bus.UNDERFLOW, 1);
        bus.RD_EN = 1'b0; step();
        chk("t1_underflow_clr", bus.UNDERFLOW, 0);
        chk("t1_rd_valid2", bus.RD_VALID, 0);

        // ---- 2: four writes then four back-to-back reads
        for (int i = 1; i <= 4; i++) begin
            bus.WR_EN = 1'b1; bus.WR_DATA = 36'(i); step();
        end
        bus.WR_EN = 1'b0;
        chk("t2_count4", bus.COUNT, 4);
        chk("t2_aempty", bus.ALMOST_EMPTY, 1);
        bus.RD_EN = 1'b1; step();
        chk("t2_valid_lat", bus.RD_VALID, 0);
        step(); chk("t2_v1", bus.RD_VALID, 1); chk("t2_d1", bus.RD_DATA, 1);
        step(); chk("t2_v2", bus.RD_VALID, 1); chk("t2_d2", bus.RD_DATA, 2);
        step(); chk("t2_v3", bus.RD_VALID, 1); chk("t2_d3", bus.RD_DATA, 3);
        bus.RD_EN = 1'b0;
        chk("t2_empty", bus.EMPTY, 1);
        step(); chk("t2_v4", bus.RD_VALID, 1); chk("t2_d4", bus.RD_DATA, 4);
        step(); chk("t2_v_end", bus.RD_VALID, 0); chk("t2_hold", bus.RD_DATA, 4);

        // ---- 3: fill to full, overflow, read+write while full
        for (int i = 0; i < 1024; i++) begin
            bus.WR_EN = 1'b1; bus.WR_DATA = 36'(i);
            if (i == 0) begin #1; chk("t3_be_on", bus.RAM_BE_A, 4'hF); end
            step();
            if (i == 1014) chk("t3_af_1015", bus.ALMOST_FULL, 0);
            if (i == 1015) chk("t3_af_1016", bus.ALMOST_FULL, 1);
            if (i == 1022) chk("t3_full_1023", bus.FULL, 0);
            if (i == 1023) begin
                chk("t3_full_1024", bus.FULL, 1);
                chk("t3_count_1024", bus.COUNT, 1024);
            end
        end
        bus.WR_DATA = 36'h123; #1;
        chk("t3_wen_blocked", bus.RAM_WEN_A, 0);
        step();
        chk("t3_overflow", bus.OVERFLOW, 1);
        chk("t3_count_hold", bus.COUNT, 1024);
        bus.RD_EN = 1'b1; #1;
        chk("t3_ren_full", bus.RAM_REN_B, 1);
        chk("t3_wen_full", bus.RAM_WEN_A, 0);
        step();
        chk("t3_count_1023", bus.COUNT, 1023);
        chk("t3_overflow2", bus.OVERFLOW, 1);
        chk("t3_full_clr", bus.FULL, 0);
        bus.RD_EN = 1'b0; bus.WR_EN = 1'b0; step();
        chk("t3_rd_valid", bus.RD_VALID, 1);
        chk("t3_rd_data0", bus.RD_DATA, 0);
        chk("t3_overflow_clr", bus.OVERFLOW, 0);

        // ---- 4: random simultaneous traffic against a scoreboard, across pointer wrap
        rst = 1'b1; step(); step(); rst = 1'b0;
        model_cnt = 0; written = 0; cyc = 0;
        saw_wrap = 1'b0; had_prev = 1'b0; prev_wa = '0;
        while ((written < 1500 || model_cnt > 0 || rd_q.size() > 0) && cyc < 20000) begin
            w = (written < 1500) && ($urandom_range(3) != 0);
            r = (written >= 1500) || ($urandom_range(1) == 1);
            wdata = {written[3:0], 32'(written * 7 + 3)};
            bus.WR_EN = w; bus.RD_EN = r; bus.WR_DATA = wdata;
            aw = w && (model_cnt != 1024);
            ar = r && (model_cnt != 0);
            #1;
            chk("t4_wen", bus.RAM_WEN_A, aw);
            chk("t4_ren", bus.RAM_REN_B, ar);
            if (ar) rd_q.push_back(exp_q.pop_front());
            if (aw) begin
                if (had_prev && prev_wa == 10'h3FF && bus.RAM_ADDR_A[14:5] == 10'h000) saw_wrap = 1'b1;
                prev_wa  = bus.RAM_ADDR_A[14:5];
                had_prev = 1'b1;
                exp_q.push_back(wdata);
                written++;
            end
            model_cnt = model_cnt + int'(aw) - int'(ar);
            step();
            chk("t4_count", bus.COUNT, model_cnt);
            if (bus.RD_VALID) begin
                if (rd_q.size() == 0) chk("t4_valid_pending", rd_q.size(), 1);
                else chk("t4_data", bus.RD_DATA, rd_q.pop_front());
            end
            cyc++;
        end
        bus.WR_EN = 1'b0; bus.RD_EN = 1'b0;
        chk("t4_written", written, 1500);
        chk("t4_drained", rd_q.size(), 0);
        chk("t4_wrap", saw_wrap, 1);
        chk("t4_empty", bus.EMPTY, 1);

        // ---- 5: reset while a read is in flight
        bus.WR_EN = 1'b1; bus.WR_DATA = 36'h1; step();
        bus.WR_EN = 1'b0; bus.RD_EN = 1'b1; step();
        bus.RD_EN = 1'b0; rst = 1'b1; step();
        chk("t5_no_valid", bus.RD_VALID, 0);
        chk("t5_count", bus.COUNT, 0);
        chk("t5_empty", bus.EMPTY, 1);
        rst = 1'b0; step();
        chk("t5_no_valid2", bus.RD_VALID, 0);
        bus.WR_EN = 1'b1; bus.WR_DATA = 36'hABCDE1234; step();
        bus.WR_EN = 1'b0; bus.RD_EN = 1'b1; step();
        bus.RD_EN = 1'b0; step();
`ifdef BRAM_FIFO_CTRL_PARITY_EN
        exp5 = 36'h9BCDE1234;   // bytes 34,12,DE,BC -> parity 1,0,0,1
`else
        exp5 = 36'hABCDE1234;
`endif
        chk("t5_valid", bus.RD_VALID, 1);
        chk("t5_data", bus.RD_DATA, exp5);
        chk("t5_parity_err", bus.PARITY_ERR, 0);

`ifdef BRAM_FIFO_CTRL_PARITY_EN
        // ---- 6: parity error injection on readback
        bus.WR_EN = 1'b1; bus.WR_DATA = 36'h011223344; step();
        bus.WR_EN = 1'b0; flip_par = 1'b1; bus.RD_EN = 1'b1; step();
        bus.RD_EN = 1'b0; step();
        chk("t6_valid_bad", bus.RD_VALID, 1);
        chk("t6_perr_bad", bus.PARITY_ERR, 1);
        flip_par = 1'b0;
        bus.WR_EN = 1'b1; bus.WR_DATA = 36'h011223344; step();
        bus.WR_EN = 1'b0; bus.RD_EN = 1'b1; step();
        bus.RD_EN = 1'b0; step();
        chk("t6_valid_ok", bus.RD_VALID, 1);
        chk("t6_perr_ok", bus.PARITY_ERR, 0);
        chk("t6_par_lane", bus.RD_DATA[35:32], 4'b0000);
        chk("t6_data", bus.RD_DATA, 36'h011223344);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
